// File: rtl/tmr_timer_pkg.sv
// Shared definitions for the TMR down timer: FSM encoding, lane indices
// and the bitwise 2-of-3 majority voter.
package tmr_timer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [1:0] LANE_0    = 2'd0;
  localparam logic [1:0] LANE_1    = 2'd1;
  localparam logic [1:0] LANE_2    = 2'd2;
  localparam logic [1:0] LANE_NONE = 2'd3;

  // Single-bit majority; callers apply it per bit for wider vectors.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/tmr_sreg.sv
// Triplicated register with bitwise majority voter, optional scrub on
// non-write cycles and per-lane XOR fault injection on the next value.
module tmr_sreg
  import tmr_timer_pkg::*;
#(
  parameter int W     = 8,
  parameter int SCRUB = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [W-1:0] d,
  input  logic         inj_en,
  input  logic [1:0]   inj_lane,
  input  logic [W-1:0] inj_mask,
  output logic [W-1:0] q,
  output logic         mism
);

  logic [W-1:0] rep_q [3];
  logic [W-1:0] rep_d [3];
  logic [W-1:0] voted;
  logic [2:0]   lane_hit;

  assign lane_hit[0] = inj_en && (inj_lane == LANE_0);
  assign lane_hit[1] = inj_en && (inj_lane == LANE_1);
  assign lane_hit[2] = inj_en && (inj_lane == LANE_2);

  // Bitwise 2-of-3 vote across the replicas.
  always_comb begin
    voted = '0;
    for (int i = 0; i < W; i++) begin
      voted[i] = maj3(rep_q[0][i], rep_q[1][i], rep_q[2][i]);
    end
  end

  // Per-lane next value: write data, else voted (scrub) or own value, then injection.
  always_comb begin
    for (int l = 0; l < 3; l++) begin
      if (we) begin
        rep_d[l] = d;
      end else if (SCRUB != 0) begin
        rep_d[l] = voted;
      end else begin
        rep_d[l] = rep_q[l];
      end
      if (lane_hit[l]) begin
        rep_d[l] = rep_d[l] ^ inj_mask;
      end
    end
  end

  // Replica storage with synchronous reset.
  // NOTE: every replica is reset explicitly; an unreset lane would raise mismatch from power-up.
  always_ff @(posedge clk) begin
    for (int l = 0; l < 3; l++) begin
      if (rst) begin
        rep_q[l] <= '0;
      end else begin
        rep_q[l] <= rep_d[l];
      end
    end
  end

  assign q    = voted;
  assign mism = (rep_q[0] != rep_q[1]) || (rep_q[1] != rep_q[2]);

endmodule

// File: rtl/tmr_down_timer.sv
// Loadable down-counting timer with triplicated count, reload and run
// registers, registered terminal-count pulse and a saturating mismatch counter.
module tmr_down_timer
  import tmr_timer_pkg::*;
#(
  parameter int W           = 8,
  parameter int SCRUB       = 1,
  parameter int AUTO_RELOAD = 0,
  parameter int EW          = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [W-1:0]  load_val,
  input  logic          en,
  output logic [W-1:0]  count,
  output logic          busy,
  output logic          tc,
  output logic          mismatch,
  output logic [EW-1:0] err_cnt,
  input  logic          inj_en,
  input  logic [1:0]    inj_lane,
  input  logic [W-1:0]  inj_mask
);

  logic [W-1:0]  count_v;
  logic [W-1:0]  reload_v;
  logic [0:0]    run_v;
  logic          count_mism;
  logic          reload_mism;
  logic          run_mism;

  logic          count_we;
  logic [W-1:0]  count_d;
  logic          reload_we;
  logic          run_we;
  state_e        state_q;
  state_e        state_d;
  logic [0:0]    run_d;
  logic          tc_d;
  logic          tc_q;
  logic [EW-1:0] err_d;
  logic [EW-1:0] err_q;

  tmr_sreg #(.W(W), .SCRUB(SCRUB)) u_count (
    .clk      (clk),
    .rst      (rst),
    .we       (count_we),
    .d        (count_d),
    .inj_en   (inj_en),
    .inj_lane (inj_lane),
    .inj_mask (inj_mask),
    .q        (count_v),
    .mism     (count_mism)
  );

  tmr_sreg #(.W(W), .SCRUB(SCRUB)) u_reload (
    .clk      (clk),
    .rst      (rst),
    .we       (reload_we),
    .d        (load_val),
    .inj_en   (1'b0),
    .inj_lane (LANE_NONE),
    .inj_mask ('0),
    .q        (reload_v),
    .mism     (reload_mism)
  );

  tmr_sreg #(.W(1), .SCRUB(SCRUB)) u_run (
    .clk      (clk),
    .rst      (rst),
    .we       (run_we),
    .d        (run_d),
    .inj_en   (1'b0),
    .inj_lane (LANE_NONE),
    .inj_mask (1'b0),
    .q        (run_v),
    .mism     (run_mism)
  );

  assign state_q = state_e'(run_v[0]);
  assign run_d   = state_d;

  // Next-state and write strobes: load beats decrement beats hold.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    count_we  = 1'b0;
    count_d   = count_v;
    reload_we = 1'b0;
    run_we    = 1'b0;
    state_d   = state_q;
    tc_d      = 1'b0;
    if (load) begin
      count_we  = 1'b1;
      count_d   = load_val;
      reload_we = 1'b1;
      run_we    = 1'b1;
      if (load_val != '0) begin
        state_d = ST_RUN;
      end else begin
        state_d = ST_IDLE;
        tc_d    = 1'b1;
      end
    end else if ((state_q == ST_RUN) && en) begin
      count_we = 1'b1;
      run_we   = 1'b1;
      if (count_v > W'(1)) begin
        count_d = count_v - W'(1);
        state_d = ST_RUN;
      end else if (AUTO_RELOAD != 0) begin
        // Terminal count (a faulted zero is treated the same way).
        count_d = reload_v;
        state_d = ST_RUN;
        tc_d    = 1'b1;
      end else begin
        count_d = '0;
        state_d = ST_IDLE;
        tc_d    = 1'b1;
      end
    end
  end

  // Saturating count of mismatch cycles.
  always_comb begin
    err_d = err_q;
    if (mismatch && (err_q != {EW{1'b1}})) begin
      err_d = err_q + EW'(1);
    end
  end

  // Terminal-count pulse and error counter registers.
  // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      tc_q  <= 1'b0;
      err_q <= '0;
    end else begin
      tc_q  <= tc_d;
      err_q <= err_d;
    end
  end

  assign count    = count_v;
  assign busy     = (state_q == ST_RUN);
  assign tc       = tc_q;
  assign mismatch = count_mism || reload_mism || run_mism;
  assign err_cnt  = err_q;

endmodule

// File: tb/tb_tmr_down_timer.sv
// Directed bench for tmr_down_timer. Three instances share one stimulus:
// dut_a (defaults), dut_b (AUTO_RELOAD=1), dut_c (SCRUB=0, EW=2).
module tb_tmr_down_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [7:0] load_val;
  logic       en;
  logic       inj_en;
  logic [1:0] inj_lane;
  logic [7:0] inj_mask;

  logic [7:0] a_count, b_count, c_count;
  logic       a_busy, b_busy, c_busy;
  logic       a_tc, b_tc, c_tc;
  logic       a_mism, b_mism, c_mism;
  logic [7:0] a_err, b_err;
  logic [1:0] c_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tmr_down_timer #(.W(8), .SCRUB(1), .AUTO_RELOAD(0), .EW(8)) dut_a (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .en(en),
    .count(a_count), .busy(a_busy), .tc(a_tc), .mismatch(a_mism), .err_cnt(a_err),
    .inj_en(inj_en), .inj_lane(inj_lane), .inj_mask(inj_mask)
  );

  tmr_down_timer #(.W(8), .SCRUB(1), .AUTO_RELOAD(1), .EW(8)) dut_b (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .en(en),
    .count(b_count), .busy(b_busy), .tc(b_tc), .mismatch(b_mism), .err_cnt(b_err),
    .inj_en(inj_en), .inj_lane(inj_lane), .inj_mask(inj_mask)
  );

  tmr_down_timer #(.W(8), .SCRUB(0), .AUTO_RELOAD(0), .EW(2)) dut_c (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .en(en),
    .count(c_count), .busy(c_busy), .tc(c_tc), .mismatch(c_mism), .err_cnt(c_err),
    .inj_en(inj_en), .inj_lane(inj_lane), .inj_mask(inj_mask)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_seq_a [5] = '{8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
  logic [7:0] exp_seq_b [7] = '{8'd2, 8'd1, 8'd3, 8'd2, 8'd1, 8'd3, 8'd2};
  logic [1:0] exp_err_c [4] = '{2'd1, 2'd2, 2'd3, 2'd3};

  initial begin
    rst = 1'b1; load = 1'b0; load_val = '0; en = 1'b0;
    inj_en = 1'b0; inj_lane = 2'd3; inj_mask = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_count", a_count, 0);
    check("rst_busy", a_busy, 0);
    check("rst_tc", a_tc, 0);
    check("rst_mism", a_mism, 0);
    check("rst_err", a_err, 0);

    // Count down from 5 with en held high.
    load = 1'b1; load_val = 8'd5; en = 1'b1;
    tick();
    load = 1'b0;
    check("ld5_count", a_count, 5);
    check("ld5_busy", a_busy, 1);
    check("ld5_tc", a_tc, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("dn_count[%0d]", i), a_count, exp_seq_a[i]);
      check($sformatf("dn_tc[%0d]", i), a_tc, (exp_seq_a[i] == 0));
      check($sformatf("dn_busy[%0d]", i), a_busy, (exp_seq_a[i] != 0));
    end
    tick();
    check("idle_count", a_count, 0);
    check("idle_tc_single", a_tc, 0);
    check("idle_busy", a_busy, 0);

    // Auto-reload from 3.
    load = 1'b1; load_val = 8'd3; en = 1'b1;
    tick();
    load = 1'b0;
    check("ar_count0", b_count, 3);
    check("ar_tc0", b_tc, 0);
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("ar_count[%0d]", i), b_count, exp_seq_b[i]);
      check($sformatf("ar_tc[%0d]", i), b_tc, (exp_seq_b[i] == 3));
      check($sformatf("ar_busy[%0d]", i), b_busy, 1);
    end

    // Load 10, en 1/0/1.
    load = 1'b1; load_val = 8'd10; en = 1'b1;
    tick();
    load = 1'b0;
    check("l10_count", a_count, 10);
    tick();
    check("en1_count", a_count, 9);
    en = 1'b0;
    tick();
    check("en0_hold", a_count, 9);
    en = 1'b1;
    tick();
    check("en1b_count", a_count, 8);
    for (int i = 0; i < 7; i++) tick();
    check("at1_count", a_count, 1);
    load = 1'b1; load_val = 8'd7;
    tick();
    load = 1'b0;
    check("reld_count", a_count, 7);
    check("reld_tc", a_tc, 0);
    check("reld_busy", a_busy, 1);

    // Hold at 0x40 and inject lane 1.
    load = 1'b1; load_val = 8'h40; en = 1'b0;
    tick();
    load = 1'b0;
    check("h40_count", a_count, 8'h40);
    check("h40_err", a_err, 0);
    check("h40_c_count", c_count, 8'h40);
    inj_en = 1'b1; inj_lane = 2'd1; inj_mask = 8'h01;
    tick();
    inj_en = 1'b0;
    check("inj_a_count", a_count, 8'h40);
    check("inj_a_mism", a_mism, 1);
    check("inj_a_err", a_err, 0);
    check("inj_c_mism", c_mism, 1);
    check("inj_c_count", c_count, 8'h40);
    tick();
    check("scrub_a_mism", a_mism, 0);
    check("scrub_a_err", a_err, 1);
    check("scrub_a_count", a_count, 8'h40);
    check("c_mism_sticky", c_mism, 1);
    check("c_err[0]", c_err, exp_err_c[0]);
    for (int i = 1; i < 4; i++) begin
      tick();
      check($sformatf("c_err[%0d]", i), c_err, exp_err_c[i]);
      check($sformatf("c_mism[%0d]", i), c_mism, 1);
    end
    check("a_err_stable", a_err, 1);
    check("a_mism_clean", a_mism, 0);

    // No-op lane leaves everything clean.
    inj_en = 1'b1; inj_lane = 2'd3;
    tick();
    inj_en = 1'b0;
    check("nop_a_mism", a_mism, 0);

    // Second upset on lane 2 outvotes the good lane in the unscrubbed copy.
    inj_en = 1'b1; inj_lane = 2'd2; inj_mask = 8'h01;
    tick();
    inj_en = 1'b0;
    check("dbl_c_count", c_count, 8'h41);
    check("dbl_c_mism", c_mism, 1);
    check("dbl_a_count", a_count, 8'h40);
    tick();
    check("dbl_a_mism", a_mism, 0);

    // Load zero from RUN: immediate terminal count.
    load = 1'b1; load_val = 8'd0;
    tick();
    load = 1'b0;
    check("lz_count", a_count, 0);
    check("lz_busy", a_busy, 0);
    check("lz_tc", a_tc, 1);
    check("lz_c_mism", c_mism, 0);
    tick();
    check("lz_tc_drop", a_tc, 0);

    // Reset mid-run together with load.
    load = 1'b1; load_val = 8'd10; en = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("mid_count", a_count, 6);
    rst = 1'b1; load = 1'b1; load_val = 8'd9;
    tick();
    rst = 1'b0; load = 1'b0;
    check("mr_count", a_count, 0);
    check("mr_busy", a_busy, 0);
    check("mr_tc", a_tc, 0);
    check("mr_err", a_err, 0);
    check("mr_c_err", c_err, 0);
    check("mr_c_mism", c_mism, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
